// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: ALU operation codes, the memory-stage FSM
// encoding, load/store size codes, and helpers for lane and byte-enable math.
package mem_stage_pkg;

   // ALU operation codes used by the execute stage
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   // Memory-stage FSM encoding
   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_RESP = 2'd2,
      MEM_DONE = 2'd3
   } mem_state_e;

   // Access size codes in funct3[1:0]; funct3[2] marks an unsigned load
   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;
   localparam int unsigned MEM_UNSIGNED_BIT = 2;

   // Load result for funct3 encodings that are not a legal load
   localparam logic [31:0] MEM_BAD_LOAD = 32'hbaadbeef;

   // Byte lane an access starts on; sub-size address bits are dropped so
   // halves land on lane 0/2 and words always on lane 0
   function automatic logic [1:0] mem_lane(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
      case (funct3[1:0])
         MEM_BYTE: return addr_lo;
         MEM_HALF: return {addr_lo[1], 1'b0};
         default:  return 2'b00;
      endcase
   endfunction

   // Byte enables for an access of the given size starting at lane
   function automatic logic [3:0] mem_be(input logic [2:0] funct3,
                                         input logic [1:0] lane);
      case (funct3[1:0])
         MEM_BYTE: return 4'b0001 << lane;
         MEM_HALF: return 4'b0011 << lane;
         default:  return 4'b1111;
      endcase
   endfunction

   // Store data replicated across all lanes so any lane picks it up
   function automatic logic [31:0] mem_wdata(input logic [2:0]  funct3,
                                             input logic [31:0] regb);
      case (funct3[1:0])
         MEM_BYTE: return {4{regb[7:0]}};
         MEM_HALF: return {2{regb[15:0]}};
         default:  return regb;
      endcase
   endfunction

   // Natural-alignment check; encoding 11 behaves like a word
   function automatic logic mem_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
      case (funct3[1:0])
         MEM_BYTE: return 1'b0;
         MEM_HALF: return addr_lo[0];
         default:  return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: shifts the returned word down to the accessed lane,
// then sign- or zero-extends according to the load funct3.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [31:0] w_shifted;

   // Lane shift followed by width extension
   always_comb begin
      w_shifted = i_rdata >> {i_lane, 3'b000};
      case (i_funct3)
         3'b000:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  o_data = w_shifted;
         3'b100:  o_data = {24'h000000, w_shifted[7:0]};
         3'b101:  o_data = {16'h0000, w_shifted[15:0]};
         default: o_data = MEM_BAD_LOAD;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Registers one load/store from EX/MEM,
// issues it on a valid/ready request channel, waits for load data,
// aligns/extends it and hands a result to writeback. Upstream is stalled
// while an access is in flight; non-memory results pass straight through.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_valid_inst,
   input  logic        ex_mem_rd_mem,
   input  logic        ex_mem_wr_mem,
   input  logic [2:0]  ex_mem_funct3,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] ex_mem_regb,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_be,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata,
   output logic [31:0] mem_result_out,
   output logic        mem_result_valid,
   output logic        mem_stall_out,
   output logic        mem_misalign_out
);

   mem_state_e  r_state;
   logic        r_req_valid;
   logic        r_req_we;
   logic [31:0] r_req_addr;
   logic [31:0] r_req_wdata;
   logic [3:0]  r_req_be;
   logic [2:0]  r_funct3;
   logic [1:0]  r_lane;
   logic [31:0] r_result;

   logic        w_is_mem;
   logic        w_start;
   logic [1:0]  w_lane;
   logic        w_misaligned;
   logic [31:0] w_load_data;

   // A store wins when both load and store are flagged
   assign w_is_mem = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
   assign w_start  = (r_state == MEM_IDLE) & w_is_mem;
   assign w_lane   = mem_lane(ex_mem_funct3, ex_mem_alu_result[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_misalign;

   assign w_misaligned = mem_misaligned(ex_mem_funct3, ex_mem_alu_result[1:0]);

   // Trap flag is set for exactly the DONE cycle following a misaligned start
   always_ff @(posedge clk) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_start & w_misaligned;
      end
   end

   assign mem_misalign_out = r_misalign;
`else
   assign w_misaligned     = 1'b0;
   assign mem_misalign_out = 1'b0;
`endif

   // Access FSM: capture request in IDLE, hold it through REQ, wait in RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= MEM_IDLE;
         r_req_valid <= 1'b0;
         r_req_we    <= 1'b0;
         r_req_addr  <= 32'h0;
         r_req_wdata <= 32'h0;
         r_req_be    <= 4'h0;
         r_funct3    <= 3'h0;
         r_lane      <= 2'h0;
         r_result    <= 32'h0;
      end else begin
         case (r_state)
            MEM_IDLE: begin
               if (w_start) begin
                  if (w_misaligned) begin
                     r_result <= 32'h0;
                     r_state  <= MEM_DONE;
                  end else begin
                     r_req_valid <= 1'b1;
                     r_req_we    <= ex_mem_wr_mem;
                     r_req_addr  <= {ex_mem_alu_result[31:2], 2'b00};
                     r_req_wdata <= mem_wdata(ex_mem_funct3, ex_mem_regb);
                     r_req_be    <= mem_be(ex_mem_funct3, w_lane);
                     r_funct3    <= ex_mem_funct3;
                     r_lane      <= w_lane;
                     // a store reports its address; a load overwrites this
                     r_result    <= ex_mem_alu_result;
                     r_state     <= MEM_REQ;
                  end
               end
            end
            MEM_REQ: begin
               if (mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= r_req_we ? MEM_DONE : MEM_RESP;
               end
            end
            MEM_RESP: begin
               if (mem_resp_valid) begin
                  r_result <= w_load_data;
                  r_state  <= MEM_DONE;
               end
            end
            MEM_DONE: begin
               r_state <= MEM_IDLE;
            end
            default: begin
               r_state <= MEM_IDLE;
            end
         endcase
      end
   end

   mem_load_align u_load_align (
      .i_funct3 (r_funct3),
      .i_lane   (r_lane),
      .i_rdata  (mem_resp_rdata),
      .o_data   (w_load_data)
   );

   assign mem_req_valid = r_req_valid;
   assign mem_req_we    = r_req_we;
   assign mem_req_addr  = r_req_addr;
   assign mem_req_wdata = r_req_wdata;
   assign mem_req_be    = r_req_be;

   // Non-memory results bypass the FSM in IDLE; everything else comes from DONE
   assign mem_result_out   = (r_state == MEM_IDLE) ? ex_mem_alu_result : r_result;
   assign mem_result_valid = ~rst &
                             (((r_state == MEM_IDLE) & ex_mem_valid_inst & ~w_is_mem) |
                              (r_state == MEM_DONE));
   assign mem_stall_out    = ~rst &
                             (w_start | (r_state == MEM_REQ) | (r_state == MEM_RESP));

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: reset checks, a vector table of load/store cases,
// hand-written reset/pass-through/misalign sequences and a randomized run
// checked against a byte-lane model of the load/store rules.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mem_valid_inst;
   logic        ex_mem_rd_mem;
   logic        ex_mem_wr_mem;
   logic [2:0]  ex_mem_funct3;
   logic [31:0] ex_mem_alu_result;
   logic [31:0] ex_mem_regb;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic [31:0] mem_result_out;
   logic        mem_result_valid;
   logic        mem_stall_out;
   logic        mem_misalign_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .rst               (rst),
      .ex_mem_valid_inst (ex_mem_valid_inst),
      .ex_mem_rd_mem     (ex_mem_rd_mem),
      .ex_mem_wr_mem     (ex_mem_wr_mem),
      .ex_mem_funct3     (ex_mem_funct3),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_regb       (ex_mem_regb),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_req_we        (mem_req_we),
      .mem_req_addr      (mem_req_addr),
      .mem_req_wdata     (mem_req_wdata),
      .mem_req_be        (mem_req_be),
      .mem_resp_valid    (mem_resp_valid),
      .mem_resp_rdata    (mem_resp_rdata),
      .mem_result_out    (mem_result_out),
      .mem_result_valid  (mem_result_valid),
      .mem_stall_out     (mem_stall_out),
      .mem_misalign_out  (mem_misalign_out)
   );

   typedef struct {
      string       tag;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] regb;
      logic [31:0] rdata;
      int          rw;
      int          sw;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
      logic [31:0] e_res;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-lane view) ----------------
   function automatic int m_size(input logic [2:0] f3);
      case (f3 % 4)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int m_lane(input logic [2:0] f3, input logic [31:0] addr);
      int n;
      n = m_size(f3);
      return ((addr % 4) / n) * n;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] be;
      int n, l;
      n = m_size(f3);
      l = m_lane(f3, addr);
      for (int i = 0; i < 4; i++) be[i] = (i >= l) && (i < l + n);
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] regb);
      logic [31:0] wd;
      int n;
      n = m_size(f3);
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = regb[8*(i % n) +: 8];
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      logic [31:0] v, b;
      v = rdata >> (8 * m_lane(f3, addr));
      case (f3)
         3'd0: begin b = v % 256;   return (b >= 128)   ? b - 256   : b; end
         3'd1: begin b = v % 65536; return (b >= 32768) ? b - 65536 : b; end
         3'd2: return v;
         3'd4: return v % 256;
         3'd5: return v % 65536;
         default: return 32'hbaadbeef;
      endcase
   endfunction

   // One memory instruction from its IDLE cycle through DONE, checking each cycle.
   // Called just after a rising edge with the DUT in IDLE.
   task automatic run_op(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] regb, input logic [31:0] rdata,
                         input int rw, input int sw,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_be, input logic [31:0] e_res);
      ex_mem_valid_inst = 1'b1;
      ex_mem_rd_mem     = rd;
      ex_mem_wr_mem     = wr;
      ex_mem_funct3     = f3;
      ex_mem_alu_result = addr;
      ex_mem_regb       = regb;
      mem_req_ready     = 1'b0;
      mem_resp_valid    = 1'b0;
      @(negedge clk);
      chk({tag, " idle stall"}, mem_stall_out, 1);
      chk({tag, " idle result_valid"}, mem_result_valid, 0);
      chk({tag, " idle req_valid"}, mem_req_valid, 0);
      for (int c = 0; c <= rw; c++) begin
         @(posedge clk); #1;
         mem_req_ready  = (c == rw);
         mem_resp_valid = (c != rw);
         mem_resp_rdata = $urandom;
         @(negedge clk);
         chk({tag, " req_valid"}, mem_req_valid, 1);
         chk({tag, " req_addr"}, mem_req_addr, e_addr);
         chk({tag, " req_be"}, mem_req_be, e_be);
         chk({tag, " req_we"}, mem_req_we, wr);
         if (wr) chk({tag, " req_wdata"}, mem_req_wdata, e_wdata);
         chk({tag, " req stall"}, mem_stall_out, 1);
         chk({tag, " req result_valid"}, mem_result_valid, 0);
      end
      if (!wr) begin
         for (int c = 0; c <= sw; c++) begin
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = (c == sw);
            mem_resp_rdata = (c == sw) ? rdata : $urandom;
            @(negedge clk);
            chk({tag, " resp req_valid"}, mem_req_valid, 0);
            chk({tag, " resp stall"}, mem_stall_out, 1);
            chk({tag, " resp result_valid"}, mem_result_valid, 0);
         end
      end
      @(posedge clk); #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      @(negedge clk);
      chk({tag, " done result_valid"}, mem_result_valid, 1);
      chk({tag, " done result"}, mem_result_out, e_res);
      chk({tag, " done stall"}, mem_stall_out, 0);
      chk({tag, " done req_valid"}, mem_req_valid, 0);
      chk({tag, " done misalign"}, mem_misalign_out, 0);
      @(posedge clk); #1;
      ex_mem_valid_inst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r_rd, r_wr;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_regb, r_rdata, r_alu;
      int          kind, r_rw, r_sw;

      vecs[0]  = '{"sb",    1'b0, 1'b1, 3'd0, 32'h1003, 32'h000000AB, 32'h0,        0, 0, 32'h1000, 32'hABABABAB, 4'b1000, 32'h1003};
      vecs[1]  = '{"lh",    1'b1, 1'b0, 3'd1, 32'h2002, 32'h0,        32'h80011234, 0, 0, 32'h2000, 32'h0,        4'b1100, 32'hFFFF8001};
      vecs[2]  = '{"lhu",   1'b1, 1'b0, 3'd5, 32'h2002, 32'h0,        32'h80011234, 0, 0, 32'h2000, 32'h0,        4'b1100, 32'h00008001};
      vecs[3]  = '{"lw_bp", 1'b1, 1'b0, 3'd2, 32'h4000, 32'h0,        32'h12345678, 3, 1, 32'h4000, 32'h0,        4'b1111, 32'h12345678};
      vecs[4]  = '{"lb",    1'b1, 1'b0, 3'd0, 32'h5001, 32'h0,        32'h00008000, 0, 0, 32'h5000, 32'h0,        4'b0010, 32'hFFFFFF80};
      vecs[5]  = '{"lbu",   1'b1, 1'b0, 3'd4, 32'h5001, 32'h0,        32'h00008000, 1, 2, 32'h5000, 32'h0,        4'b0010, 32'h00000080};
      vecs[6]  = '{"sh",    1'b0, 1'b1, 3'd1, 32'h6002, 32'h1234BEEF, 32'h0,        2, 0, 32'h6000, 32'hBEEFBEEF, 4'b1100, 32'h6002};
      vecs[7]  = '{"sw",    1'b0, 1'b1, 3'd2, 32'h7000, 32'hCAFEF00D, 32'h0,        0, 0, 32'h7000, 32'hCAFEF00D, 4'b1111, 32'h7000};
      vecs[8]  = '{"lbad",  1'b1, 1'b0, 3'd3, 32'h8000, 32'h0,        32'h11111111, 0, 0, 32'h8000, 32'h0,        4'b1111, 32'hBAADBEEF};
      vecs[9]  = '{"rdwr",  1'b1, 1'b1, 3'd0, 32'h9002, 32'h0000005A, 32'h0,        0, 0, 32'h9000, 32'h5A5A5A5A, 4'b0100, 32'h9002};
      vecs[10] = '{"lb3",   1'b1, 1'b0, 3'd0, 32'hA003, 32'h0,        32'h7F000000, 0, 0, 32'hA000, 32'h0,        4'b1000, 32'h0000007F};
      vecs[11] = '{"sw11",  1'b0, 1'b1, 3'd3, 32'hB000, 32'h01020304, 32'h0,        0, 0, 32'hB000, 32'h01020304, 4'b1111, 32'hB000};

      // reset with a memory op presented: nothing may start, outputs at reset values
      rst               = 1'b1;
      ex_mem_valid_inst = 1'b1;
      ex_mem_rd_mem     = 1'b1;
      ex_mem_wr_mem     = 1'b0;
      ex_mem_funct3     = 3'd2;
      ex_mem_alu_result = 32'h100;
      ex_mem_regb       = 32'h0;
      mem_req_ready     = 1'b0;
      mem_resp_valid    = 1'b0;
      mem_resp_rdata    = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req_valid", mem_req_valid, 0);
      chk("rst req_we", mem_req_we, 0);
      chk("rst req_addr", mem_req_addr, 0);
      chk("rst req_wdata", mem_req_wdata, 0);
      chk("rst req_be", mem_req_be, 0);
      chk("rst misalign", mem_misalign_out, 0);
      chk("rst result_valid", mem_result_valid, 0);
      chk("rst stall", mem_stall_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      ex_mem_valid_inst = 1'b0;

      // non-memory pass-through, stray response ignored
      ex_mem_valid_inst = 1'b1;
      ex_mem_rd_mem     = 1'b0;
      ex_mem_wr_mem     = 1'b0;
      ex_mem_alu_result = 32'hDEADBEEF;
      mem_resp_valid    = 1'b1;
      @(negedge clk);
      chk("pass result_valid", mem_result_valid, 1);
      chk("pass result", mem_result_out, 32'hDEADBEEF);
      chk("pass stall", mem_stall_out, 0);
      chk("pass req_valid", mem_req_valid, 0);
      @(posedge clk); #1;
      ex_mem_valid_inst = 1'b0;
      @(negedge clk);
      chk("invalid result_valid", mem_result_valid, 0);
      chk("invalid stall", mem_stall_out, 0);
      chk("invalid req_valid", mem_req_valid, 0);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;

      // vector table, issued back-to-back
      for (int i = 0; i < 12; i++)
         run_op(vecs[i].tag, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                vecs[i].regb, vecs[i].rdata, vecs[i].rw, vecs[i].sw,
                vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be, vecs[i].e_res);

      // reset while waiting for load data, then a late response
      ex_mem_valid_inst = 1'b1;
      ex_mem_rd_mem     = 1'b1;
      ex_mem_wr_mem     = 1'b0;
      ex_mem_funct3     = 3'd2;
      ex_mem_alu_result = 32'h4440;
      @(posedge clk); #1;
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("rstresp req_valid", mem_req_valid, 1);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("rstresp in_resp stall", mem_stall_out, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstresp rst stall", mem_stall_out, 0);
      chk("rstresp rst result_valid", mem_result_valid, 0);
      @(posedge clk); #1;
      rst               = 1'b0;
      ex_mem_valid_inst = 1'b0;
      mem_resp_valid    = 1'b1;
      mem_resp_rdata    = 32'h77777777;
      @(negedge clk);
      chk("rstresp req_valid", mem_req_valid, 0);
      chk("rstresp req_addr", mem_req_addr, 0);
      chk("rstresp req_be", mem_req_be, 0);
      chk("rstresp req_wdata", mem_req_wdata, 0);
      chk("rstresp req_we", mem_req_we, 0);
      chk("rstresp result_valid", mem_result_valid, 0);
      chk("rstresp stall", mem_stall_out, 0);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      chk("rstresp late result_valid", mem_result_valid, 0);
      chk("rstresp late stall", mem_stall_out, 0);
      @(posedge clk); #1;

      // misaligned accesses
`ifdef MEM_MISALIGN_TRAP_EN
      ex_mem_valid_inst = 1'b1;
      ex_mem_rd_mem     = 1'b1;
      ex_mem_wr_mem     = 1'b0;
      ex_mem_funct3     = 3'd2;
      ex_mem_alu_result = 32'h3001;
      @(negedge clk);
      chk("mis idle stall", mem_stall_out, 1);
      chk("mis idle req_valid", mem_req_valid, 0);
      @(posedge clk); #1;
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("mis req_valid", mem_req_valid, 0);
      chk("mis misalign", mem_misalign_out, 1);
      chk("mis result_valid", mem_result_valid, 1);
      chk("mis result", mem_result_out, 0);
      chk("mis stall", mem_stall_out, 0);
      @(posedge clk); #1;
      ex_mem_valid_inst = 1'b0;
      mem_req_ready     = 1'b0;
      @(negedge clk);
      chk("mis after misalign", mem_misalign_out, 0);
      chk("mis after result_valid", mem_result_valid, 0);
      @(posedge clk); #1;
`else
      run_op("lw_mis", 1'b1, 1'b0, 3'd2, 32'h3001, 32'h0, 32'hA5A5A5A5, 0, 0,
             32'h3000, 32'h0, 4'b1111, 32'hA5A5A5A5);
      run_op("lh_odd", 1'b1, 1'b0, 3'd1, 32'h2003, 32'h0, 32'h80011234, 0, 0,
             32'h2000, 32'h0, 4'b1100, 32'hFFFF8001);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            r_alu             = $urandom;
            ex_mem_valid_inst = 1'b1;
            ex_mem_rd_mem     = 1'b0;
            ex_mem_wr_mem     = 1'b0;
            ex_mem_alu_result = r_alu;
            mem_resp_valid    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rnd pass result_valid", mem_result_valid, 1);
            chk("rnd pass result", mem_result_out, r_alu);
            chk("rnd pass stall", mem_stall_out, 0);
            chk("rnd pass req_valid", mem_req_valid, 0);
            @(posedge clk); #1;
            ex_mem_valid_inst = 1'b0;
            mem_resp_valid    = 1'b0;
         end else begin
            r_wr    = (kind == 3);
            r_rd    = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            r_f3    = r_wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            r_addr  = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
            r_addr  = r_addr - (r_addr % m_size(r_f3));
`endif
            r_regb  = $urandom;
            r_rdata = $urandom;
            r_rw    = $urandom_range(0, 3);
            r_sw    = $urandom_range(0, 3);
            run_op("rnd", r_rd, r_wr, r_f3, r_addr, r_regb, r_rdata, r_rw, r_sw,
                   r_addr - (r_addr % 4), m_wdata(r_f3, r_regb), m_be(r_f3, r_addr),
                   r_wr ? r_addr : m_load(r_f3, r_addr, r_rdata));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and writeback. Consumes the EX/MEM-registered ALU result (effective address or arithmetic result), store data and load/store control. Issues byte-enabled data-memory requests over a valid/ready request channel plus a response channel. Aligns and sign- or zero-extends load data, and stalls upstream until each memory operation completes.

## Interface
Parameters: none. Widths are fixed at 32-bit data/address.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- ex_mem_valid_inst  in  1  instruction in this stage is valid.
- ex_mem_rd_mem  in  1  load.
- ex_mem_wr_mem  in  1  store.
- ex_mem_funct3  in  3  access size/sign (RV32I load/store funct3).
- ex_mem_alu_result  in  32  byte address for loads/stores; pass-through result otherwise.
- ex_mem_regb  in  32  store data (rs2).
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  32  word address, bits [1:0] = 0.
- mem_req_wdata  out  32  lane-replicated store data.
- mem_req_be  out  4  byte enables.
- mem_resp_valid  in  1  load data valid.
- mem_resp_rdata  in  32  load word.
- mem_result_out  out  32  result to writeback.
- mem_result_valid  out  1  mem_result_out is valid this cycle.
- mem_stall_out  out  1  hold EX/MEM and all upstream stages.
- mem_misalign_out  out  1  misaligned access flagged (see Configuration).

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, valid non-memory instruction: mem_result_out = ex_mem_alu_result and mem_result_valid = 1, same cycle, no stall.
- IDLE, valid memory op: mem_stall_out = 1. Request fields (addr, we, be, wdata, funct3, addr[1:0]) are registered and the FSM goes to REQ.
- REQ: mem_req_valid = 1 with all request fields held stable until mem_req_ready. On handshake, a store goes to DONE and a load goes to RESP.
- RESP: wait for mem_resp_valid. On it, register the aligned/extended load data and go to DONE.
- DONE: mem_result_valid = 1, mem_stall_out = 0, FSM returns to IDLE next cycle. mem_result_out is the load data, or the registered address for a store.
- Stall: mem_stall_out = (IDLE & valid memop) | REQ | RESP. Upstream holds its inputs stable while stalled; the block relies only on its registered copies after IDLE.
- Byte enables:
  - byte (funct3[1:0] = 00): be = 4'b0001 << addr[1:0]; wdata = {4{regb[7:0]}}.
  - half (01): be = 4'b0011 << {addr[1],1'b0}; wdata = {2{regb[15:0]}}.
  - word (10): be = 4'b1111.
  - funct3[1:0] = 11: treated as word.
- Load align: shift rdata right by addr[1:0]*8, then extend by funct3:
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
  - Other encodings: result 32'hbaadbeef.
- If ex_mem_rd_mem and ex_mem_wr_mem are both set, the op is treated as a store.
- mem_resp_valid outside RESP is ignored.
- ex_mem_valid_inst = 0 never issues a request and gives mem_result_valid = 0.

## Timing
- Reset values: FSM = IDLE, mem_req_valid = 0, mem_req_we = 0, mem_req_addr = 0, mem_req_wdata = 0, mem_req_be = 0, mem_misalign_out = 0, registered result = 0.
- mem_result_valid and mem_stall_out are forced 0 in any cycle where rst = 1.
- Reset mid-operation: next state is IDLE and mem_req_valid drops next cycle. A late response after reset is ignored.
- Store, instruction presented at cycle N with ready = 1 in REQ: REQ at N+1, DONE at N+2. Minimum 3 cycles, stall asserted at N and N+1.
- Load with ready = 1 at N+1 and response at N+2: DONE at N+3. Minimum 4 cycles.
- The response may arrive no earlier than the cycle after the request handshake.
- Back-to-back memory ops: the second is seen in IDLE at the cycle after DONE.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no request.
  - The FSM goes IDLE -> DONE directly; DONE asserts mem_misalign_out = 1 and mem_result_out = 0.
- MEM_MISALIGN_TRAP_EN undefined:
  - mem_misalign_out is tied to 0.
  - Word accesses ignore addr[1:0]; half accesses ignore addr[0].

## Structure
- FSM state encoding, and the load/store size funct3 constants (`MEM_BYTE`, `MEM_HALF`, `MEM_WORD`, unsigned flag bit), go in the shared sys_defs definitions alongside the ALU constants.
- One sub-module, mem_load_align: combinational rdata shift plus sign/zero extension, keyed by funct3 and addr[1:0]. It is instantiated once.

## Test plan
- Store-byte: SB, addr 0x1003, regb 0x000000AB, ready = 1 -> be = 4'b1000, addr = 0x1000, wdata = 0xABABABAB; stall for 2 cycles; DONE at N+2.
- Load-half signed: LH, addr 0x2002, rdata 0x8001_1234 -> mem_result_out = 0xFFFF8001 at N+3; LHU at the same address -> 0x00008001.
- Backpressure: LW with mem_req_ready low for 3 cycles -> req_valid and addr/be stable for all 4 REQ cycles, stall held, result valid only after the response.
- Non-memory pass-through: ADD result 0xDEADBEEF -> mem_result_valid = 1 in the same cycle, stall = 0, mem_req_valid = 0.
- Reset in RESP: assert rst, then pulse mem_resp_valid -> FSM IDLE, no result_valid, all outputs at reset values.
- Misaligned LW at 0x3001:
  - With MEM_MISALIGN_TRAP_EN: no request; mem_misalign_out = 1 at N+1.
  - Without the macro: request addr = 0x3000, be = 4'b1111.
